// File: rtl/gpu_cmd_ctrl_pkg.sv
// Shared types and text-mode geometry for the GPU command sequencer.
package gpu_pkg;

    localparam int TEXT_MODE_WIDTH  = 80;
    localparam int TEXT_MODE_HEIGHT = 60;
    localparam int DISPLAY_WIDTH    = 640;
    localparam int DISPLAY_HEIGHT   = 480;
    localparam int AW               = $clog2(TEXT_MODE_WIDTH * TEXT_MODE_HEIGHT);

    typedef enum logic [1:0] {
        SIG_STORE_BYTE  = 2'b00,
        SIG_MOVE_CURSOR = 2'b01,
        SIG_DISPLAY     = 2'b10,
        SIG_CLEAR       = 2'b11
    } gpu_cmd_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        DISP_WAIT = 2'd2
    } gpu_state_e;

endpackage

// File: rtl/gpu_cmd_ctrl_if.sv
// Command, framebuffer and scan-out handshake bundle of the GPU command sequencer.
interface gpu_cmd_ctrl_if #(
    parameter int AW = gpu_pkg::AW
);
    logic          interrupt_enable;
    logic [1:0]    interrupt_in;
    logic [7:0]    data_in;
    logic          busy;
    logic          overrun;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic [6:0]    cursor_x;
    logic [5:0]    cursor_y;
    logic          disp_req;
    logic          disp_ack;

    modport master (
        output interrupt_enable, interrupt_in, data_in, disp_ack,
        input  busy, overrun, fb_we, fb_addr, fb_wdata, cursor_x, cursor_y, disp_req
    );

    modport slave (
        input  interrupt_enable, interrupt_in, data_in, disp_ack,
        output busy, overrun, fb_we, fb_addr, fb_wdata, cursor_x, cursor_y, disp_req
    );
endinterface

// File: rtl/gpu_cmd_ctrl_cursor.sv
// Text cursor: column, row and linear cell index kept in step without a multiplier.
// Build option GPU_CURSOR_WRAP_EN: advancing past the last cell wraps to the origin instead of holding.
module gpu_cursor #(
    parameter int TEXT_W = gpu_pkg::TEXT_MODE_WIDTH,
    parameter int TEXT_H = gpu_pkg::TEXT_MODE_HEIGHT,
    parameter int AW     = $clog2(TEXT_W * TEXT_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_advance,
    input  logic          i_load,
    input  logic          i_origin,
    input  logic [6:0]    i_load_x,
    input  logic [5:0]    i_load_y,
    output logic [6:0]    o_x,
    output logic [5:0]    o_y,
    output logic [AW-1:0] o_idx
);
    localparam logic [6:0]    X_LAST    = 7'(TEXT_W - 1);
    localparam logic [AW-1:0] LAST_CELL = AW'(TEXT_W * TEXT_H - 1);

    logic [6:0]    r_x;
    logic [5:0]    r_y;
    logic [AW-1:0] r_idx;

    // Row start address as a shift-and-add over the set bits of TEXT_W.
    function automatic logic [AW-1:0] row_base(input logic [5:0] y);
        logic [AW-1:0] acc;
        acc = '0;
        for (int b = 0; b < AW; b++) begin
            if (((TEXT_W >> b) & 1) != 0) acc = acc + (AW'(y) << b);
        end
        return acc;
    endfunction

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_origin) begin
            r_x   <= '0;
            r_y   <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_x   <= i_load_x;
            r_y   <= i_load_y;
            r_idx <= row_base(i_load_y) + AW'(i_load_x);
        end else if (i_advance) begin
            if (r_x != X_LAST) begin
                r_x   <= r_x + 7'd1;
                r_idx <= r_idx + AW'(1);
            end else if (r_idx != LAST_CELL) begin
                r_x   <= '0;
                r_y   <= r_y + 6'd1;
                r_idx <= r_idx + AW'(1);
            end else begin
`ifdef GPU_CURSOR_WRAP_EN
                r_x   <= '0;
                r_y   <= '0;
                r_idx <= '0;
`endif
            end
        end
    end

    assign o_x   = r_x;
    assign o_y   = r_y;
    assign o_idx = r_idx;
endmodule

// File: rtl/gpu_cmd_ctrl.sv
// Text-mode GPU command sequencer: strobed commands become framebuffer writes, a clear sweep
// and a display handshake. End-of-screen cursor behaviour follows GPU_CURSOR_WRAP_EN (gpu_cursor).
module gpu_cmd_ctrl
    import gpu_pkg::*;
#(
    parameter int TEXT_W = TEXT_MODE_WIDTH,
    parameter int TEXT_H = TEXT_MODE_HEIGHT
) (
    input  logic          clk,
    input  logic          rst,
    gpu_cmd_ctrl_if.slave bus
);
    localparam int            AW        = $clog2(TEXT_W * TEXT_H);
    localparam logic [AW-1:0] LAST_CELL = AW'(TEXT_W * TEXT_H - 1);

    gpu_state_e    r_state;
    gpu_state_e    w_next_state;
    logic [AW-1:0] r_sweep;
    logic [7:0]    r_fill;
    logic          r_move_pend;
    logic [6:0]    r_move_x;
    logic          r_overrun;
    logic          r_fb_we;
    logic [AW-1:0] r_fb_addr;
    logic [7:0]    r_fb_wdata;

    gpu_cmd_e      w_cmd;
    logic          w_accept;
    logic          w_drop;
    logic          w_sweep_last;
    logic [6:0]    w_move_x;
    logic [5:0]    w_move_y;
    logic          w_busy;
    logic          w_disp_req;
    logic [6:0]    w_cur_x;
    logic [5:0]    w_cur_y;
    logic [AW-1:0] w_cur_idx;

    assign w_cmd        = gpu_cmd_e'(bus.interrupt_in);
    assign w_accept     = bus.interrupt_enable && (r_state == IDLE);
    assign w_drop       = bus.interrupt_enable && (r_state != IDLE);
    assign w_sweep_last = (r_state == CLEAR) && (r_sweep == LAST_CELL);
    assign w_move_x     = (bus.data_in >= 8'(TEXT_W)) ? 7'(TEXT_W - 1) : bus.data_in[6:0];
    assign w_move_y     = (bus.data_in >= 8'(TEXT_H)) ? 6'(TEXT_H - 1) : bus.data_in[5:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_cmd == SIG_DISPLAY) w_next_state = DISP_WAIT;
                if (w_accept && w_cmd == SIG_CLEAR)   w_next_state = CLEAR;
            end
            CLEAR:     if (r_sweep == LAST_CELL) w_next_state = IDLE;
            DISP_WAIT: if (bus.disp_ack)         w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state == CLEAR) || (r_state == DISP_WAIT);
        w_disp_req = (r_state == DISP_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb_we     <= 1'b0;
            r_fb_addr   <= '0;
            r_fb_wdata  <= '0;
            r_sweep     <= '0;
            r_fill      <= '0;
            r_overrun   <= 1'b0;
            r_move_pend <= 1'b0;
            r_move_x    <= '0;
        end else begin
            r_fb_we <= 1'b0;
            if (w_drop) r_overrun <= 1'b1;
            if (r_state == CLEAR) begin
                r_fb_we    <= 1'b1;
                r_fb_addr  <= r_sweep;
                r_fb_wdata <= r_fill;
                r_sweep    <= r_sweep + AW'(1);
            end
            if (w_accept) begin
                // Any command other than a first-half move abandons a pending X.
                r_move_pend <= (w_cmd == SIG_MOVE_CURSOR) && !r_move_pend;
                unique case (w_cmd)
                    SIG_STORE_BYTE: begin
                        r_fb_we    <= 1'b1;
                        r_fb_addr  <= w_cur_idx;
                        r_fb_wdata <= bus.data_in;
                    end
                    SIG_MOVE_CURSOR: if (!r_move_pend) r_move_x <= w_move_x;
                    SIG_CLEAR: begin
                        r_fill  <= bus.data_in;
                        r_sweep <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    gpu_cursor #(
        .TEXT_W (TEXT_W),
        .TEXT_H (TEXT_H),
        .AW     (AW)
    ) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_accept && w_cmd == SIG_STORE_BYTE),
        .i_load    (w_accept && w_cmd == SIG_MOVE_CURSOR && r_move_pend),
        .i_origin  (w_sweep_last),
        .i_load_x  (r_move_x),
        .i_load_y  (w_move_y),
        .o_x       (w_cur_x),
        .o_y       (w_cur_y),
        .o_idx     (w_cur_idx)
    );

    assign bus.busy     = w_busy;
    assign bus.overrun  = r_overrun;
    assign bus.fb_we    = r_fb_we;
    assign bus.fb_addr  = r_fb_addr;
    assign bus.fb_wdata = r_fb_wdata;
    assign bus.cursor_x = w_cur_x;
    assign bus.cursor_y = w_cur_y;
    assign bus.disp_req = w_disp_req;
endmodule

// File: tb/tb_gpu_cmd_ctrl.sv
// Scoreboard bench for gpu_cmd_ctrl: a behavioural model queues expected framebuffer writes,
// a monitor pops them on every fb_we, and cursor/status outputs are compared each cycle.
module tb_gpu_cmd_ctrl;
    localparam int W = 80;
    localparam int H = 60;
    localparam int CELLS = W * H;
    localparam logic [1:0] ST = 2'b00;
    localparam logic [1:0] MV = 2'b01;
    localparam logic [1:0] DS = 2'b10;
    localparam logic [1:0] CL = 2'b11;
    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_DISP  = 2;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];

    int m_mode = M_IDLE;
    int m_left = 0;
    int m_fill = 0;
    int cx = 0;
    int cy = 0;
    int px = 0;
    int pend = 0;
    int m_ovr = 0;

    gpu_cmd_ctrl_if bus ();

    gpu_cmd_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_advance();
        if (cx < W - 1) begin
            cx++;
        end else if (cy < H - 1) begin
            cx = 0;
            cy++;
        end else begin
`ifdef GPU_CURSOR_WRAP_EN
            cx = 0;
            cy = 0;
`endif
        end
    endtask

    task automatic model_cmd(input logic [1:0] c, input int d);
        case (c)
            ST: begin
                pend = 0;
                exp_q.push_back('{cy * W + cx, d});
                model_advance();
            end
            MV: begin
                if (pend == 0) begin
                    pend = 1;
                    px = (d > W - 1) ? W - 1 : d;
                end else begin
                    cx = px;
                    cy = (d > H - 1) ? H - 1 : d;
                    pend = 0;
                end
            end
            DS: begin
                pend = 0;
                m_mode = M_DISP;
            end
            default: begin
                pend = 0;
                m_mode = M_CLEAR;
                m_left = CELLS;
                m_fill = d;
            end
        endcase
    endtask

    // One clock: drive inputs at a falling edge, update the model for the coming rising edge,
    // then compare status outputs at the next falling edge.
    task automatic cycle(input logic ie, input logic [1:0] c, input logic [7:0] d,
                         input logic ack, input logic r);
        int prev;
        bus.interrupt_enable = ie;
        bus.interrupt_in     = c;
        bus.data_in          = d;
        bus.disp_ack         = ack;
        rst                  = r;
        prev = m_mode;
        if (r) begin
            m_mode = M_IDLE;
            cx = 0; cy = 0; px = 0; pend = 0; m_ovr = 0; m_left = 0;
        end else begin
            if (ie && prev != M_IDLE) m_ovr = 1;
            if (ie && prev == M_IDLE) model_cmd(c, int'(d));
            if (prev == M_CLEAR) begin
                exp_q.push_back('{CELLS - m_left, m_fill});
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_IDLE;
                    cx = 0;
                    cy = 0;
                end
            end else if (prev == M_DISP && ack) begin
                m_mode = M_IDLE;
            end
        end
        @(negedge clk);
        check("cursor_x", 32'(bus.cursor_x), cx);
        check("cursor_y", 32'(bus.cursor_y), cy);
        check("busy",     32'(bus.busy),     32'(m_mode != M_IDLE));
        check("disp_req", 32'(bus.disp_req), 32'(m_mode == M_DISP));
        check("overrun",  32'(bus.overrun),  m_ovr);
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] d);
        cycle(1'b1, c, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, ST, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs();
        check("rst_fb_we",    32'(bus.fb_we),    0);
        check("rst_fb_addr",  32'(bus.fb_addr),  0);
        check("rst_fb_wdata", 32'(bus.fb_wdata), 0);
    endtask

    // Write monitor: every observed fb_we must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.fb_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.fb_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("fb_addr",  32'(bus.fb_addr),  e.addr);
                    check("fb_wdata", 32'(bus.fb_wdata), e.data);
                end
            end
        end
    end

    initial begin
        int busy_cnt;
        rst                  = 1'b1;
        bus.interrupt_enable = 1'b0;
        bus.interrupt_in     = ST;
        bus.data_in          = 8'h00;
        bus.disp_ack         = 1'b0;
        @(negedge clk);
        cycle(1'b0, ST, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, ST, 8'h00, 1'b0, 1'b1);
        check_zero_outputs();

        cmd(ST, 8'h41);
        idle(1);
        cmd(MV, 8'h05);
        cmd(MV, 8'h03);
        cmd(ST, 8'h42);
        idle(1);
        cmd(MV, 8'hFF);
        cmd(MV, 8'hFF);
        idle(1);
        cmd(MV, 8'h10);
        cmd(ST, 8'h43);
        cmd(MV, 8'h07);
        idle(2);
        cmd(ST, 8'h44);
        cmd(MV, 8'd78);
        cmd(MV, 8'd2);
        for (int i = 0; i < 5; i++) cmd(ST, 8'(8'h60 + i));
        idle(1);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'b0);
        end
        cycle(1'b0, ST, 8'h00, 1'b1, 1'b0);
        idle(1);

        cmd(CL, 8'h20);
        busy_cnt = int'(bus.busy);
        for (int k = 1; k <= CELLS; k++) begin
            cycle((k == 2000) || (k == CELLS), ST, 8'h99, 1'b0, 1'b0);
            busy_cnt += int'(bus.busy);
        end
        check("clear_busy_cycles", busy_cnt, CELLS);
        idle(2);

        cycle(1'b0, ST, 8'h00, 1'b0, 1'b1);
        cmd(DS, 8'h55);
        idle(9);
        cycle(1'b1, ST, 8'h77, 1'b1, 1'b0);
        idle(2);

        cmd(CL, 8'h5A);
        idle(100);
        cycle(1'b0, ST, 8'h00, 1'b0, 1'b1);
        check_zero_outputs();
        idle(20);

        check("writes_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
